// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN             : data/address width
//   INSTR_BYTES      : byte stride between consecutive instructions
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fq_state_e       : front-end FSM states
package fetch_queue_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with a synchronous flush.
//   clk, reset   : clock, asynchronous active-low reset
//   i_flush      : empty the FIFO; overrides push and pop
//   i_push/i_data: write an entry; ignored when full unless a pop frees a slot
//   i_pop        : drop the head entry; ignored when empty
//   o_data       : head entry (undefined when empty)
//   o_count      : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  // Storage needs no reset; entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, issues word fetches to instruction memory, buffers the
// returned words with PC / PC+4 for decode, and handles redirects from execute.
//   clk, reset                        : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         : fetch request channel
//   imem_resp_valid/data              : in-order fetch responses
//   redirect_valid/pc                 : taken branch/jump; flushes and refetches
//   id_valid/ready/instr/pc/pcplus4   : head of the instruction queue to decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pcplus4
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fq_state_e         r_state;
  logic [XLEN-1:0]   r_pc;
  logic [CW-1:0]     r_drop;

  logic [CW-1:0]     w_q_count;
  logic [CW-1:0]     w_out_count;
  logic [XLEN-1:0]   w_shadow_pc;
  logic [3*XLEN-1:0] w_head;
  logic              w_credit;
  logic              w_req_fire;
  logic              w_resp;
  logic              w_resp_keep;
  logic              w_pop;

  // Buffered plus in-flight fetches (stale ones included) may never exceed DEPTH,
  // so a returning response always finds room in the queue.
  assign w_credit = ({1'b0, w_q_count} + {1'b0, w_out_count}) < DEPTH_W;

  assign imem_req_valid = (r_state == RUN) && !redirect_valid && w_credit;
  assign imem_req_addr  = (r_state == RUN) ? r_pc : '0;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding cannot belong to us; ignore it.
  assign w_resp      = imem_resp_valid && (w_out_count != '0);
  assign w_resp_keep = w_resp && !redirect_valid && (r_drop == '0);
  assign w_pop       = id_valid && id_ready && !redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_drop  <= '0;
    end else begin
      case (r_state)
        BOOT:    r_state <= RUN;
        RUN:     r_state <= RUN;
        default: r_state <= BOOT;
      endcase

      if (redirect_valid) begin
        r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (w_req_fire) begin
        r_pc <= r_pc + XLEN'(INSTR_BYTES);
      end

      // Everything still in flight after a redirect is stale; no request fires
      // in the redirect cycle, so that is the shadow count minus this response.
      if (redirect_valid) begin
        r_drop <= w_out_count - CW'(w_resp);
      end else if (w_resp && (r_drop != '0)) begin
        r_drop <= r_drop - 1'b1;
      end
    end
  end

  // PC of each outstanding request, popped as its response returns.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_shadow (
    .clk     (clk),
    .reset   (reset),
    .i_flush (1'b0),
    .i_push  (w_req_fire),
    .i_data  (r_pc),
    .i_pop   (w_resp),
    .o_data  (w_shadow_pc),
    .o_count (w_out_count)
  );

  sync_fifo #(
    .WIDTH (3 * XLEN),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_resp_keep),
    .i_data  ({imem_resp_data, w_shadow_pc, w_shadow_pc + XLEN'(INSTR_BYTES)}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_q_count)
  );

  // Gate the head so every id_* output reads zero while the queue is empty.
  assign id_valid   = (w_q_count != '0);
  assign id_instr   = id_valid ? w_head[3*XLEN-1:2*XLEN] : '0;
  assign id_pc      = id_valid ? w_head[2*XLEN-1:XLEN]   : '0;
  assign id_pcplus4 = id_valid ? w_head[XLEN-1:0]        : '0;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = '0;
  logic        redirect_valid  = 1'b0;
  logic [31:0] redirect_pc     = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_instr, id_pc, id_pcplus4;

  // Second instance for the address wrap case: always-ready memory, latency 1.
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_resp_valid = 1'b0;
  logic [31:0] w_resp_data  = '0;
  logic        w_id_valid;
  logic [31:0] w_id_instr, w_id_pc, w_id_pcplus4;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
    .clk (clk), .reset (reset),
    .imem_req_valid (imem_req_valid), .imem_req_ready (imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_resp_valid (imem_resp_valid), .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
    .id_valid (id_valid), .id_ready (id_ready), .id_instr (id_instr),
    .id_pc (id_pc), .id_pcplus4 (id_pcplus4)
  );

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk (clk), .reset (reset),
    .imem_req_valid (w_req_valid), .imem_req_ready (1'b1),
    .imem_req_addr (w_req_addr),
    .imem_resp_valid (w_resp_valid), .imem_resp_data (w_resp_data),
    .redirect_valid (1'b0), .redirect_pc (32'h0),
    .id_valid (w_id_valid), .id_ready (1'b1), .id_instr (w_id_instr),
    .id_pc (w_id_pc), .id_pcplus4 (w_id_pcplus4)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    w_resp_valid <= w_req_valid;
    w_resp_data  <= mem_word(w_req_addr);
  end

  // Reference model: fetch stream, memory in flight, and what decode should see.
  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } req_t;

  req_t        pend[$];
  logic [31:0] bufq[$];
  int unsigned epoch = 0;
  int unsigned cyc   = 0;
  logic [31:0] fetch_m = 32'h0;
  bit          running_m = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  bit          g_rdy = 1'b0, g_idr = 1'b0, g_redir = 1'b0;
  logic [31:0] g_rpc = '0;
  int unsigned g_lat = 1;

  logic [31:0] req_log[$], pop_pc_log[$], pop_p4_log[$];
  bit          wlog_en = 1'b0;
  logic [31:0] wreq_log[$], wid_pc_log[$], wid_p4_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a negedge with g_* set; returns at the next negedge.
  task automatic run_cycle();
    req_t        r;
    bit          resp, exp_rv, exp_iv;
    resp = (pend.size() != 0) && (pend[0].due <= cyc);
    imem_req_ready  = g_rdy;
    id_ready        = g_idr;
    redirect_valid  = g_redir;
    redirect_pc     = g_rpc;
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(pend[0].addr) : 32'h0;
    #1;
    exp_rv = running_m && !g_redir && ((bufq.size() + pend.size()) < DEPTH);
    exp_iv = (bufq.size() != 0);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", imem_req_addr, fetch_m);
    chk("id_valid", {31'b0, id_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      chk("id_pc", id_pc, bufq[0]);
      chk("id_pcplus4", id_pcplus4, bufq[0] + 32'd4);
      chk("id_instr", id_instr, mem_word(bufq[0]));
    end
    if (wlog_en) begin
      if (w_req_valid) wreq_log.push_back(w_req_addr);
      if (w_id_valid) begin
        wid_pc_log.push_back(w_id_pc);
        wid_p4_log.push_back(w_id_pcplus4);
      end
    end
    if (imem_req_valid && g_rdy) req_log.push_back(imem_req_addr);
    if (g_redir) begin
      if (resp) void'(pend.pop_front());
      epoch++;
      fetch_m = {g_rpc[31:2], 2'b00};
      bufq.delete();
    end else begin
      if (exp_iv && g_idr) begin
        pop_pc_log.push_back(id_pc);
        pop_p4_log.push_back(id_pcplus4);
        void'(bufq.pop_front());
      end
      if (resp) begin
        r = pend.pop_front();
        if (r.epoch == epoch) bufq.push_back(r.addr);
      end
      if (exp_rv && g_rdy) begin
        pend.push_back('{addr: fetch_m, epoch: epoch, due: cyc + g_lat});
        fetch_m += 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    running_m = reset;
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    #3;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_pcplus4", id_pcplus4, 32'h0);
    chk("rst_wrap_addr", w_req_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Streaming from reset with an always-ready 1-cycle memory.
    g_rdy = 1; g_idr = 1; g_lat = 1; wlog_en = 1;
    repeat (8) run_cycle();
    wlog_en = 0;
    chk("boot_addr0", req_log[0], 32'h0);
    chk("boot_addr1", req_log[1], 32'h4);
    chk("boot_addr2", req_log[2], 32'h8);
    chk("boot_addr3", req_log[3], 32'hC);
    chk("boot_pc0", pop_pc_log[0], 32'h0);
    chk("boot_pc1", pop_pc_log[1], 32'h4);
    chk("boot_pc2", pop_pc_log[2], 32'h8);
    chk("boot_p4_0", pop_p4_log[0], 32'h4);
    chk("boot_p4_2", pop_p4_log[2], 32'hC);
    chk("wrap_addr0", wreq_log[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", wreq_log[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", wreq_log[2], 32'h0);
    chk("wrap_pc1", wid_pc_log[1], 32'hFFFF_FFFC);
    chk("wrap_p4_1", wid_p4_log[1], 32'h0);

    // Decode stalled: exactly DEPTH fetches, then one more per pop.
    req_log.delete();
    g_idr = 0; g_redir = 1; g_rpc = 32'h200;
    run_cycle();
    g_redir = 0;
    repeat (10) run_cycle();
    chk("stall_reqs", 32'(req_log.size()), 32'd4);
    chk("stall_valid", {31'b0, imem_req_valid}, 32'h0);
    g_idr = 1;
    run_cycle();
    g_idr = 0;
    repeat (6) run_cycle();
    chk("stall_one_more", 32'(req_log.size()), 32'd5);

    // Redirect with two slow requests in flight; both must be dropped.
    g_idr = 1; g_lat = 4; g_redir = 1; g_rpc = 32'h40;
    run_cycle();
    g_redir = 0;
    repeat (2) run_cycle();
    pop_pc_log.delete(); pop_p4_log.delete();
    g_redir = 1; g_rpc = 32'h0000_0103; g_lat = 1;
    run_cycle();
    g_redir = 0;
    repeat (10) run_cycle();
    chk("redir_pc", pop_pc_log[0], 32'h100);
    chk("redir_p4", pop_p4_log[0], 32'h104);

    // Memory not ready for three cycles: address must hold.
    repeat (6) run_cycle();
    g_redir = 1; g_rpc = 32'h10;
    run_cycle();
    g_redir = 0; g_rdy = 0;
    repeat (3) begin
      chk("hold_addr", imem_req_addr, 32'h10);
      run_cycle();
    end
    req_log.delete();
    g_rdy = 1;
    repeat (2) run_cycle();
    chk("hold_fire0", req_log[0], 32'h10);
    chk("hold_fire1", req_log[1], 32'h14);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      g_rdy   = ($urandom_range(0, 3) != 0);
      g_idr   = ($urandom_range(0, 2) != 0);
      g_redir = ($urandom_range(0, 15) == 0);
      g_rpc   = $urandom;
      g_lat   = $urandom_range(1, 4);
      run_cycle();
    end

    // Reset mid-stream with buffered entries and requests in flight.
    g_rdy = 1; g_idr = 1; g_redir = 0; g_lat = 1;
    repeat (8) run_cycle();
    g_redir = 1; g_rpc = 32'h300;
    run_cycle();
    g_redir = 0; g_idr = 0;
    repeat (2) run_cycle();
    g_lat = 40;
    repeat (4) run_cycle();
    chk("pre_rst_id_valid", {31'b0, id_valid}, 32'h1);
    chk("pre_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("async_id_valid", {31'b0, id_valid}, 32'h0);
    chk("async_id_pc", id_pc, 32'h0);
    chk("async_req_valid", {31'b0, imem_req_valid}, 32'h0);
    pend.delete(); bufq.delete();
    epoch++; fetch_m = 32'h0; running_m = 0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    reset = 1'b1;
    req_log.delete(); pop_pc_log.delete(); pop_p4_log.delete();
    g_idr = 1; g_lat = 1;
    repeat (6) run_cycle();
    chk("restart_addr", req_log[0], 32'h0);
    chk("restart_pc", pop_pc_log[0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
